// File: rtl/rf_dbg_pkg.sv
// Shared types and constants for the register-file debug access arbiter.
package rf_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STALL  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dbg_state_e;

    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int CNT_W            = 4;

endpackage

// File: rtl/regfile_dbg_arbiter.sv
// Debug port into the register file: freezes the pipeline, lets WB drain,
// then borrows the RF write port or the rs1 read port for a single cycle.
module regfile_dbg_arbiter
    import rf_dbg_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_req_write,
    input  logic [4:0]            dbg_req_addr,
    input  logic [DATA_WIDTH-1:0] dbg_req_wdata,

    output logic                  dbg_rsp_valid,
    input  logic                  dbg_rsp_ready,
    output logic [DATA_WIDTH-1:0] dbg_rsp_rdata,
    output logic                  dbg_rsp_err,

    output logic                  stall_req,

    input  logic                  wb_reg_write_en,
    input  logic [4:0]            wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] wb_rd_data,
    input  logic [4:0]            id_rs1_addr,

    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [4:0]            rf_rs1_addr,
    input  logic [DATA_WIDTH-1:0] rf_rs1_data
);

    dbg_state_e            state;
    logic [CNT_W-1:0]      drain_cnt;
    logic                  req_write;
    logic [4:0]            req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (dbg_req_valid) begin
                        req_write <= dbg_req_write;
                        req_addr  <= dbg_req_addr;
                        req_wdata <= dbg_req_wdata;
                        drain_cnt <= CNT_W'(DRAIN_CYCLES);
                        state     <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    // A WB write still in flight at the end of the drain holds off
                    // the access so it lands before the debug port takes over.
                    if (drain_cnt != '0)
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    else if (!wb_reg_write_en)
                        state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    rsp_rdata <= req_write ? '0 : rf_rs1_data;
                    rsp_err   <= req_write && (req_addr == 5'd0);
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (dbg_rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_req_ready = (state == ST_IDLE);
    assign dbg_rsp_valid = (state == ST_RESP);
    assign stall_req     = (state != ST_IDLE);
    assign dbg_rsp_rdata = rsp_rdata;
    assign dbg_rsp_err   = rsp_err;

    // The debug port only owns the RF ports during ACCESS; a debug read
    // leaves the write port with WB since it only needs rs1.
    always_comb begin
        rf_we       = wb_reg_write_en;
        rf_waddr    = wb_rd_addr;
        rf_wdata    = wb_rd_data;
        rf_rs1_addr = id_rs1_addr;
        if (state == ST_ACCESS) begin
            if (req_write) begin
                rf_we    = (req_addr != 5'd0);
                rf_waddr = req_addr;
                rf_wdata = req_wdata;
            end else begin
                rf_rs1_addr = req_addr;
            end
        end
    end

endmodule
